// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Round-robin lock arbiter for the single packet-SRAM port. A master raises
//   req_i for a whole multi-access transaction and keeps the port until it
//   drops req_i. The holder's SRAM bus is muxed onto the pins. Read data is
//   broadcast to every master.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   req_i[NUM_REQ]      per-master lock request
//   m_ce_i / m_we_i     per-master chip / write enable
//   m_addr_i            per-master address, master k at [k*ADDR_W +: ADDR_W]
//   m_width_i           per-master access width (bytes), 4 bits per master
//   m_data_i            per-master write data, DATA_W bits per master
//   grant_o             registered one-hot grant
//   grant_idx_o         holder index (valid while busy_o)
//   busy_o              a grant is active
//   rdata_o             sram_data_i passthrough
//   hold_timeout_o      one-cycle pulse on the MAX_HOLD-th granted cycle
//   sram_*_o            SRAM pins, gated by the live grant
//   sram_data_i         SRAM read data (1-cycle read latency)
module sram_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [NUM_REQ-1:0]          m_ce_i,
   input  logic [NUM_REQ-1:0]          m_we_i,
   input  logic [NUM_REQ*ADDR_W-1:0]   m_addr_i,
   input  logic [NUM_REQ*4-1:0]        m_width_i,
   input  logic [NUM_REQ*DATA_W-1:0]   m_data_i,
   output logic [NUM_REQ-1:0]          grant_o,
   output logic [2:0]                  grant_idx_o,
   output logic                        busy_o,
   output logic [DATA_W-1:0]           rdata_o,
   output logic                        hold_timeout_o,
   output logic                        sram_ce_o,
   output logic                        sram_we_o,
   output logic [ADDR_W-1:0]           sram_addr_o,
   output logic [3:0]                  sram_width_o,
   output logic [DATA_W-1:0]           sram_data_o,
   input  logic [DATA_W-1:0]           sram_data_i
);

   localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_HOLD);
   // Counter holds (granted cycles - 1), so the MAX_HOLD-th granted cycle
   // is the one where the counter equals MAX_HOLD-1.
   localparam logic [CNT_W-1:0] CNT_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
   localparam logic [2:0]       IDX_TOP  = 3'(NUM_REQ - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [2:0]           idx_q, idx_d;
   logic [2:0]           rr_q, rr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // First requester at or after 'start' in circular order: {found, index}.
   function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                          input logic [2:0] start);
      logic [3:0] res;
      int         k;
      res = '0;
      // Scan from the far end so the closest requester wins last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         k = int'(start) + i;
         if (k >= NUM_REQ) k = k - NUM_REQ;
         if (|(r & (NUM_REQ'(1) << k))) res = {1'b1, 3'(k)};
      end
      return res;
   endfunction

   //--------------------------------------------------------------------------
   // State registers
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   //--------------------------------------------------------------------------
   // Next-state / arbitration
   //--------------------------------------------------------------------------
   logic       holder_req;
   logic [2:0] rr_next;
   logic [3:0] pick_idle, pick_hand;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      idx_d      = idx_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      holder_req = |(grant_q & req_i);
      rr_next    = (idx_q == IDX_TOP) ? 3'd0 : idx_q + 3'd1;
      pick_idle  = rr_pick(req_i, rr_q);
      pick_hand  = rr_pick(req_i, rr_next);

      unique case (state_q)
         IDLE: begin
            if (pick_idle[3]) begin
               state_d = BUSY;
               grant_d = NUM_REQ'(1) << pick_idle[2:0];
               idx_d   = pick_idle[2:0];
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (holder_req) begin
               if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            end else begin
               // Release edge: pointer moves past the holder and, if anyone
               // else is waiting, the grant hands off with no idle cycle.
               rr_d = rr_next;
               if (pick_hand[3]) begin
                  grant_d = NUM_REQ'(1) << pick_hand[2:0];
                  idx_d   = pick_hand[2:0];
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  idx_d   = '0;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_o        = grant_q;
   assign grant_idx_o    = idx_q;
   assign busy_o         = (state_q == BUSY);
   assign hold_timeout_o = (MAX_HOLD != 0) && busy_o && (cnt_q == CNT_LAST);
   assign rdata_o        = sram_data_i;

   //--------------------------------------------------------------------------
   // SRAM mux. Only a holder that still asserts req_i drives the pins, so a
   // residual grant cycle after release never reaches the SRAM. Reset clears
   // grant_q asynchronously, which zeroes the pins without a clock.
   //--------------------------------------------------------------------------
   logic [NUM_REQ-1:0] live;

   always_comb begin
      live         = grant_q & req_i;
      sram_ce_o    = |(live & m_ce_i);
      sram_we_o    = |(live & m_ce_i & m_we_i);
      sram_addr_o  = '0;
      sram_width_o = '0;
      sram_data_o  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (live[k]) begin
            sram_addr_o  = sram_addr_o  | m_addr_i[k*ADDR_W +: ADDR_W];
            sram_width_o = sram_width_o | m_width_i[k*4 +: 4];
            sram_data_o  = sram_data_o  | m_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   req_i = '0, m_ce_i = '0, m_we_i = '0;
   logic [127:0] m_addr_i = '0, m_data_i = '0;
   logic [15:0]  m_width_i = '0;
   logic [3:0]   grant_o;
   logic [2:0]   grant_idx_o;
   logic         busy_o, hold_timeout_o, sram_ce_o, sram_we_o;
   logic [31:0]  rdata_o, sram_addr_o, sram_data_o;
   logic [3:0]   sram_width_o;
   logic [31:0]  sram_data_i = '0;

   int n_vec = 0;
   int n_err = 0;
   int wr_cnt = 0;

   sram_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .MAX_HOLD(8)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .m_ce_i(m_ce_i), .m_we_i(m_we_i),
      .m_addr_i(m_addr_i), .m_width_i(m_width_i), .m_data_i(m_data_i),
      .grant_o(grant_o), .grant_idx_o(grant_idx_o), .busy_o(busy_o),
      .rdata_o(rdata_o), .hold_timeout_o(hold_timeout_o),
      .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
      .sram_width_o(sram_width_o), .sram_data_o(sram_data_o),
      .sram_data_i(sram_data_i)
   );

   always #5 clk = ~clk;

   // SRAM model: 1-cycle read latency, read pattern {addr[15:0], C0DE}.
   always @(posedge clk) begin
      if (sram_ce_o && !sram_we_o) sram_data_i <= {sram_addr_o[15:0], 16'hC0DE};
      if (sram_ce_o && sram_we_o)  wr_cnt <= wr_cnt + 1;
   end

   task automatic test_reset;
      m_ce_i = 4'hF;
      m_addr_i[31:0] = 32'h55;
      #3;
      n_vec++; if (grant_o !== 4'b0000) begin n_err++; $display("FAIL rst_grant got %b want 0000", grant_o); end
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy_o); end
      n_vec++; if (grant_idx_o !== 3'd0) begin n_err++; $display("FAIL rst_idx got %0d want 0", grant_idx_o); end
      n_vec++; if (hold_timeout_o !== 1'b0) begin n_err++; $display("FAIL rst_timeout got %b want 0", hold_timeout_o); end
      n_vec++; if (sram_ce_o !== 1'b0 || sram_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_sram got ce=%b addr=%h want 0/0", sram_ce_o, sram_addr_o); end
      @(negedge clk);
      rst = 1'b1;
      m_ce_i = '0;
      m_addr_i = '0;
   endtask

   task automatic test_single;
      @(negedge clk);
      req_i = 4'b0001; m_ce_i = 4'b0001; m_we_i = '0;
      m_addr_i[31:0] = 32'h10; m_width_i[3:0] = 4'd4;
      #1;
      n_vec++; if (grant_o !== 4'b0000) begin n_err++; $display("FAIL single_latency got %b want 0000", grant_o); end
      @(negedge clk);
      n_vec++; if (grant_o !== 4'b0001 || busy_o !== 1'b1 || grant_idx_o !== 3'd0) begin n_err++; $display("FAIL single_grant got %b/%b/%0d want 0001/1/0", grant_o, busy_o, grant_idx_o); end
      n_vec++; if (sram_ce_o !== 1'b1 || sram_we_o !== 1'b0 || sram_addr_o !== 32'h10 || sram_width_o !== 4'd4) begin n_err++; $display("FAIL single_mux got ce=%b we=%b addr=%h w=%0d want 1/0/10/4", sram_ce_o, sram_we_o, sram_addr_o, sram_width_o); end
      @(negedge clk);
      n_vec++; if (rdata_o !== 32'h0010C0DE) begin n_err++; $display("FAIL single_rdata got %h want 0010c0de", rdata_o); end
      repeat (3) @(negedge clk);
      req_i = '0;
      #1;
      n_vec++; if (grant_o !== 4'b0001 || sram_ce_o !== 1'b0) begin n_err++; $display("FAIL single_residual got grant=%b ce=%b want 0001/0", grant_o, sram_ce_o); end
      @(negedge clk);
      n_vec++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin n_err++; $display("FAIL single_release got %b/%b want 0000/0", grant_o, busy_o); end
      m_ce_i = '0;
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      req_i = 4'b1111; m_ce_i = 4'b1111; m_we_i = '0;
      for (int k = 0; k < 4; k++) begin
         m_addr_i[k*32 +: 32] = 32'h100 + 32'(k);
         m_width_i[k*4 +: 4] = 4'd4;
      end
      for (int k = 0; k < 4; k++) begin
         exp = 4'd1 << k;
         @(negedge clk);
         n_vec++; if (grant_o !== exp || busy_o !== 1'b1 || grant_idx_o !== 3'(k)) begin n_err++; $display("FAIL b2b_grant%0d got %b/%b/%0d want %b/1/%0d", k, grant_o, busy_o, grant_idx_o, exp, k); end
         n_vec++; if (sram_addr_o !== 32'h100 + 32'(k)) begin n_err++; $display("FAIL b2b_addr%0d got %h want %h", k, sram_addr_o, 32'h100 + 32'(k)); end
         repeat (2) @(negedge clk);
         @(negedge clk);
         req_i[k] = 1'b0;
         #1;
         n_vec++; if (sram_ce_o !== 1'b0 || busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_resid%0d got ce=%b busy=%b want 0/1", k, sram_ce_o, busy_o); end
      end
      @(negedge clk);
      n_vec++; if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b/%b want 0000/0", grant_o, busy_o); end
      // Pointer should be back at 0 after master 3 released.
      req_i = 4'b1111;
      @(negedge clk);
      n_vec++; if (grant_o !== 4'b0001) begin n_err++; $display("FAIL b2b_rr0 got %b want 0001", grant_o); end
      req_i = '0;
      repeat (2) @(negedge clk);
      m_ce_i = '0;
   endtask

   task automatic test_no_preempt;
      req_i = 4'b0100;
      @(negedge clk);
      n_vec++; if (grant_o !== 4'b0100) begin n_err++; $display("FAIL np_grant2 got %b want 0100", grant_o); end
      req_i = 4'b1101;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++; if (grant_o !== 4'b0100) begin n_err++; $display("FAIL np_hold%0d got %b want 0100", i, grant_o); end
      end
      req_i = 4'b1001;
      @(negedge clk);
      n_vec++; if (grant_o !== 4'b1000 || grant_idx_o !== 3'd3) begin n_err++; $display("FAIL np_to3 got %b/%0d want 1000/3", grant_o, grant_idx_o); end
      req_i = 4'b0001;
      @(negedge clk);
      n_vec++; if (grant_o !== 4'b0001 || busy_o !== 1'b1) begin n_err++; $display("FAIL np_to0 got %b/%b want 0001/1", grant_o, busy_o); end
      req_i = '0;
      @(negedge clk);
      n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL np_idle got %b want 0", busy_o); end
   endtask

   task automatic test_residual_gate;
      int w;
      req_i = 4'b0010; m_ce_i = 4'b1010; m_we_i = 4'b0010;
      m_addr_i[32 +: 32] = 32'h20; m_addr_i[96 +: 32] = 32'h30;
      m_data_i[32 +: 32] = 32'hDEADBEEF; m_width_i[4 +: 4] = 4'd2;
      @(negedge clk);
      n_vec++; if (sram_ce_o !== 1'b1 || sram_we_o !== 1'b1 || sram_addr_o !== 32'h20 || sram_data_o !== 32'hDEADBEEF || sram_width_o !== 4'd2) begin n_err++; $display("FAIL gate_write got ce=%b we=%b addr=%h d=%h w=%0d want 1/1/20/deadbeef/2", sram_ce_o, sram_we_o, sram_addr_o, sram_data_o, sram_width_o); end
      req_i = '0;
      #1;
      n_vec++; if (sram_ce_o !== 1'b0 || sram_we_o !== 1'b0 || sram_addr_o !== 32'h0) begin n_err++; $display("FAIL gate_resid got ce=%b we=%b addr=%h want 0/0/0", sram_ce_o, sram_we_o, sram_addr_o); end
      w = wr_cnt;
      @(negedge clk);
      n_vec++; if (wr_cnt !== w || grant_o !== 4'b0000) begin n_err++; $display("FAIL gate_nowrite got writes=%0d grant=%b want %0d/0000", wr_cnt, grant_o, w); end
      // One-cycle request pulse still earns a (gated) granted cycle.
      req_i = 4'b0100; m_ce_i = 4'b0100; m_we_i = '0;
      @(negedge clk);
      req_i = '0;
      #1;
      n_vec++; if (grant_o !== 4'b0100 || sram_ce_o !== 1'b0) begin n_err++; $display("FAIL pulse_grant got %b ce=%b want 0100/0", grant_o, sram_ce_o); end
      @(negedge clk);
      n_vec++; if (grant_o !== 4'b0000) begin n_err++; $display("FAIL pulse_release got %b want 0000", grant_o); end
      m_ce_i = '0; m_we_i = '0;
   endtask

   task automatic test_hold_timeout;
      int pulses;
      pulses = 0;
      req_i = 4'b0010;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (hold_timeout_o === 1'b1) pulses++;
         n_vec++; if (hold_timeout_o !== (k == 8) || grant_o !== 4'b0010) begin n_err++; $display("FAIL hold_cyc%0d got to=%b grant=%b want %b/0010", k, hold_timeout_o, grant_o, (k == 8)); end
      end
      n_vec++; if (pulses != 1) begin n_err++; $display("FAIL hold_pulses got %0d want 1", pulses); end
      req_i = '0;
      repeat (2) @(negedge clk);
      n_vec++; if (busy_o !== 1'b0 || hold_timeout_o !== 1'b0) begin n_err++; $display("FAIL hold_idle got busy=%b to=%b want 0/0", busy_o, hold_timeout_o); end
   endtask

   task automatic test_async_reset;
      req_i = 4'b1000; m_ce_i = 4'b1000;
      @(negedge clk);
      n_vec++; if (grant_o !== 4'b1000 || sram_ce_o !== 1'b1) begin n_err++; $display("FAIL arst_pre got %b ce=%b want 1000/1", grant_o, sram_ce_o); end
      #2 rst = 1'b0;
      #1;
      n_vec++; if (grant_o !== 4'b0000 || busy_o !== 1'b0 || sram_ce_o !== 1'b0) begin n_err++; $display("FAIL arst_clear got %b/%b ce=%b want 0000/0/0", grant_o, busy_o, sram_ce_o); end
      req_i = 4'b0100; m_ce_i = 4'b0100;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_vec++; if (grant_o !== 4'b0100 || grant_idx_o !== 3'd2) begin n_err++; $display("FAIL arst_regrant got %b/%0d want 0100/2", grant_o, grant_idx_o); end
      req_i = '0; m_ce_i = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_no_preempt;
      test_residual_gate;
      test_hold_timeout;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Round-robin arbiter that shares the single packet-SRAM port among NUM_REQ masters: executor, cksum, parser and deparser.
- A master locks the port for a multi-access transaction (for example an instruction fetch sequence or a checksum pass) and keeps it until it drops its request.
- The SRAM bus of the current grant holder is muxed onto the SRAM pins. Read data is broadcast to all masters.
- Replaces the ad-hoc per-module sram_mux selectors with one shared arbitration point.

Parameters:
- NUM_REQ, 4, number of masters (2..8).
- ADDR_W, 32, SRAM address width.
- DATA_W, 32, SRAM data width.
- MAX_HOLD, 1024, grant-hold cycles before hold_timeout_o pulses; 0 disables the check.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  NUM_REQ  per-master lock request; held high for the whole transaction.
- m_ce_i  in  NUM_REQ  per-master SRAM chip enable.
- m_we_i  in  NUM_REQ  per-master write enable.
- m_addr_i  in  NUM_REQ*ADDR_W  per-master address; master k occupies bits [k*ADDR_W +: ADDR_W].
- m_width_i  in  NUM_REQ*4  per-master access width in bytes (1/2/4).
- m_data_i  in  NUM_REQ*DATA_W  per-master write data.
- grant_o  out  NUM_REQ  one-hot grant, registered.
- grant_idx_o  out  3  index of the holder; valid only while busy_o=1.
- busy_o  out  1  a grant is active.
- rdata_o  out  DATA_W  SRAM read data, broadcast to all masters (sram_data_i passthrough).
- hold_timeout_o  out  1  one-cycle pulse when the holder reaches MAX_HOLD granted cycles.
- sram_ce_o  out  1  SRAM chip enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  ADDR_W  SRAM address.
- sram_width_o  out  4  SRAM access width.
- sram_data_o  out  DATA_W  SRAM write data.
- sram_data_i  in  DATA_W  SRAM read data; 1-cycle synchronous read latency.

Behaviour:
- Reset (rst=0, asynchronous):
  - grant_o=0, grant_idx_o=0, busy_o=0, hold_timeout_o=0.
  - Round-robin pointer rr=0, hold counter=0.
  - SRAM outputs read as 0 immediately, because they are gated by grant.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - At the first clk edge where any req_i bit is high, grant the first requester at or after rr in circular order.
  - grant_o and busy_o go high after that edge. Request-to-grant latency is 1 cycle.
  - Move to BUSY and clear the hold counter.
- BUSY, holder g:
  - Grant stays on g while req_i[g]=1. Other requests wait; there is no preemption.
  - At the edge where req_i[g] is sampled low, rr becomes g+1 mod NUM_REQ.
  - In that same edge, if other requests are pending, grant the next requester round-robin from the new rr and stay in BUSY. Handoff has zero bubble.
  - Otherwise clear grant_o and return to IDLE.
- SRAM mux (combinational):
  - When busy_o=1 and req_i[g]=1: sram_ce_o=m_ce_i[g], sram_we_o=m_we_i[g]&m_ce_i[g], and addr/width/data come from slice g.
  - Otherwise all SRAM outputs are 0, so a master that has dropped req_i cannot access the SRAM in its residual grant cycle.
  - Masters that are not granted are ignored completely.
- rdata_o = sram_data_i, unregistered.
  - Data for an access issued in cycle t is valid in cycle t+1, even if the grant has already moved on.
  - The master owns this timing: it must keep req_i high until its last read data arrives.
- Fairness:
  - Simultaneous requests resolve by circular priority starting at rr.
  - A continuously requesting master is served within NUM_REQ-1 transactions of other masters.
- Hold counter:
  - Increments each BUSY cycle with the same holder, saturating at MAX_HOLD.
  - hold_timeout_o pulses exactly once, on the cycle the count reaches MAX_HOLD; the grant is not revoked.
  - The counter clears on every new grant.
- A req_i bit that pulses high for a single cycle and is granted still receives at least one granted cycle. Its SRAM outputs stay gated if req_i is already low.

Test Plan:
1. Reset, then req_i=4'b0001 held 5 cycles with m_addr 0x10 read → grant_o=0001 one cycle after req; sram_addr_o=0x10; rdata_o carries the 0x10 data the following cycle; after req drops, grant_o=0 next cycle.
2. req_i=4'b1111 held with each master dropping after 3 cycles → grant order 0,1,2,3 with zero idle cycles between handoffs; rr ends at 0.
3. Master 2 holds while masters 0 and 3 request → no preemption; on master 2 release the grant goes to 3 (rr=3), then to 0.
4. Granted master drops req_i while still driving m_ce_i=1 → sram_ce_o=0 in that residual cycle; no write occurs.
5. MAX_HOLD=8 and master 1 held 20 cycles → hold_timeout_o high for exactly one cycle, on the 8th granted cycle; grant is unchanged.
6. rst asserted asynchronously mid-transaction (between clock edges) → grant_o, busy_o and sram_ce_o go to 0 without waiting for clk; after rst deasserts, pending req_i=0100 is granted to master 2 one cycle later.
